// File: rtl/sms_latch_driver_if.sv
// Command handshake between the sequencer and the latch driver.
// One command in flight; the master holds valid/ch/op until it sees ready at an edge.
interface sms_latch_driver_if;
  logic cmd_valid;
  logic cmd_ready;
  logic cmd_ch;
  logic cmd_op;

  modport master (output cmd_valid, output cmd_ch, output cmd_op, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_ch, input cmd_op, output cmd_ready);
endinterface

// File: rtl/sms_latch_driver.sv
// Pulses one set/clear line of a two-channel latch card, then reads back its state.
// done at PULSE+SETTLE+2 after accept; ready stays low until the command retires.
module sms_latch_driver #(
  parameter int unsigned PULSE_CYCLES  = 4,
  parameter int unsigned SETTLE_CYCLES = 8
) (
  input  logic                clk,
  input  logic                r,
  sms_latch_driver_if.slave   cmd,
  output logic [1:0]          set_n,
  output logic [1:0]          clr_n,
  input  logic [1:0]          fb_true,
  input  logic [1:0]          fb_comp,
  output logic                done,
  output logic                done_ok,
  output logic [1:0]          err_code
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PULSE,
    S_SETTLE,
    S_CHECK,
    S_DONE
  } state_t;

  localparam logic [7:0] PULSE_LD  = 8'(PULSE_CYCLES - 1);
  localparam logic [7:0] SETTLE_LD = 8'(SETTLE_CYCLES - 1);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       ch_q, ch_d;
  logic       op_q, op_d;
  logic [1:0] set_n_q, set_n_d;
  logic [1:0] clr_n_q, clr_n_d;
  logic       ready_q, ready_d;
  logic       done_q, done_d;
  logic       ok_q, ok_d;
  logic [1:0] err_q, err_d;

  // Feedback is asynchronous to clk; two flops per bit before use.
  logic [1:0] ft_meta_q, ft_sync_q;
  logic [1:0] fc_meta_q, fc_sync_q;
  logic       fb_t, fb_c;

  assign fb_t = ft_sync_q[ch_q];
  assign fb_c = fc_sync_q[ch_q];

  always_ff @(posedge clk or negedge r) begin
    if (!r) begin
      ft_meta_q <= 2'b00;
      ft_sync_q <= 2'b00;
      fc_meta_q <= 2'b00;
      fc_sync_q <= 2'b00;
    end else begin
      ft_meta_q <= fb_true;
      ft_sync_q <= ft_meta_q;
      fc_meta_q <= fb_comp;
      fc_sync_q <= fc_meta_q;
    end
  end

  always_ff @(posedge clk or negedge r) begin
    if (!r) begin
      state_q <= S_IDLE;
      cnt_q   <= 8'd0;
      ch_q    <= 1'b0;
      op_q    <= 1'b0;
      set_n_q <= 2'b11;
      clr_n_q <= 2'b11;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      ok_q    <= 1'b0;
      err_q   <= 2'b00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ch_q    <= ch_d;
      op_q    <= op_d;
      set_n_q <= set_n_d;
      clr_n_q <= clr_n_d;
      ready_q <= ready_d;
      done_q  <= done_d;
      ok_q    <= ok_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ch_d    = ch_q;
    op_d    = op_q;
    done_d  = 1'b0;
    ok_d    = ok_q;
    err_d   = err_q;

    case (state_q)
      S_IDLE: begin
        if (cmd.cmd_valid && ready_q) begin
          ch_d    = cmd.cmd_ch;
          op_d    = cmd.cmd_op;
          cnt_d   = PULSE_LD;
          state_d = S_PULSE;
        end
      end
      S_PULSE: begin
        if (cnt_q == 8'd0) begin
          cnt_d   = SETTLE_LD;
          state_d = S_SETTLE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      S_SETTLE: begin
        if (cnt_q == 8'd0) begin
          state_d = S_CHECK;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      S_CHECK: begin
        // true == comp means the latch is in its illegal state; that outranks a wrong value.
        state_d = S_DONE;
        done_d  = 1'b1;
        if (fb_t == fb_c) begin
          ok_d  = 1'b0;
          err_d = 2'b10;
        end else if (fb_t != op_q) begin
          ok_d  = 1'b0;
          err_d = 2'b01;
        end else begin
          ok_d  = 1'b1;
          err_d = 2'b00;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Drive lines are decoded from the next state so they come straight off flops.
    set_n_d = 2'b11;
    clr_n_d = 2'b11;
    if (state_d == S_PULSE) begin
      if (op_d) begin
        set_n_d[ch_d] = 1'b0;
      end else begin
        clr_n_d[ch_d] = 1'b0;
      end
    end
    ready_d = (state_d == S_IDLE);
  end

  assign cmd.cmd_ready = ready_q;
  assign set_n         = set_n_q;
  assign clr_n         = clr_n_q;
  assign done          = done_q;
  assign done_ok       = ok_q;
  assign err_code      = err_q;

endmodule
